// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, ALU operation codes and a bit-reversal helper.
// The ALU operation code is {funct7[5], funct3}, with LUI on the otherwise unused code 1001.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // Lets a single right-shift network also perform left shifts.
    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/riscv_alu_if.sv
// Operand/result bundle between the datapath and the ALU.
// The datapath side drives operation and operands; the ALU side returns the results.
interface riscv_alu_if;
    import riscv_pkg::*;

    logic [3:0]      alu_fun;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] result_q;
    logic            zero;

    modport master (
        output alu_fun, srcA, srcB,
        input  result, result_q, zero
    );

    modport slave (
        input  alu_fun, srcA, srcB,
        output result, result_q, zero
    );

endinterface

// File: rtl/riscv_alu_shifter.sv
// Five-stage logarithmic barrel shifter for SLL/SRL/SRA with a 5-bit shift amount.
// Left shifts reuse the right-shift stages by reversing the data on the way in and out.
module riscv_alu_shifter
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  logic            left,
    input  logic            arith,
    output logic [XLEN-1:0] shifted
);

    logic [XLEN-1:0] stage [0:5];
    logic            fill;

    // Sign fill only applies to arithmetic right shifts; left shifts always fill zero.
    assign fill     = arith & ~left & data[XLEN-1];
    assign stage[0] = left ? bit_reverse(data) : data;

    for (genvar g = 0; g < 5; g++) begin : g_stage
        localparam int unsigned S = 1 << g;
        assign stage[g+1] = shamt[g] ? {{S{fill}}, stage[g][XLEN-1:S]} : stage[g];
    end

    assign shifted = left ? bit_reverse(stage[5]) : stage[5];

endmodule

// File: rtl/riscv_alu.sv
// RV32I integer ALU: combinational result and zero flag, plus a registered copy of the result.
// Unused operation codes produce zero so no X ever reaches the datapath.
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    riscv_alu_if.slave  alu
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] shift_out;
    logic             shift_left;
    logic             shift_arith;
    logic             lt_signed;
    logic             lt_unsigned;

    assign shift_left  = (alu.alu_fun == ALU_SLL);
    assign shift_arith = (alu.alu_fun == ALU_SRA);
    assign lt_signed   = $signed(alu.srcA) < $signed(alu.srcB);
    assign lt_unsigned = alu.srcA < alu.srcB;

    riscv_alu_shifter u_shifter (
        .data    (alu.srcA),
        .shamt   (alu.srcB[4:0]),
        .left    (shift_left),
        .arith   (shift_arith),
        .shifted (shift_out)
    );

    always_comb begin
        result = '0;
        case (alu.alu_fun)
            ALU_ADD:  result = alu.srcA + alu.srcB;
            ALU_SUB:  result = alu.srcA - alu.srcB;
            ALU_OR:   result = alu.srcA | alu.srcB;
            ALU_AND:  result = alu.srcA & alu.srcB;
            ALU_XOR:  result = alu.srcA ^ alu.srcB;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result = shift_out;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_LUI:  result = alu.srcA;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result;
        end
    end

    assign alu.result   = result;
    assign alu.result_q = result_q;
    assign alu.zero     = (result == '0);

endmodule

// File: tb/tb_riscv_alu.sv
// Scoreboard bench for riscv_alu: a driver applies one directed vector per cycle and queues its
// hand-computed result; a monitor checks result, zero and result_q one cycle later.
module tb_riscv_alu;
    import riscv_pkg::*;

    typedef struct {
        string       name;
        logic        in_rst;
        logic [31:0] exp_res;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    riscv_alu_if bus ();

    riscv_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input string name, input logic in_rst, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        exp_t e;
        @(negedge clk);
        rst_n       = ~in_rst;
        bus.alu_fun = f;
        bus.srcA    = a;
        bus.srcB    = b;
        e.name      = name;
        e.in_rst    = in_rst;
        e.exp_res   = exp_res;
        exp_q.push_back(e);
    endtask

    // Inputs stay stable from the driving negedge until the next one, so the combinational
    // outputs can be checked alongside the freshly registered copy.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check32({e.name, " result"}, bus.result, e.exp_res);
                check32({e.name, " zero"}, {31'b0, bus.zero}, {31'b0, (e.exp_res == 32'h0)});
                check32({e.name, " result_q"}, bus.result_q, e.in_rst ? 32'h0 : e.exp_res);
            end
        end
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.alu_fun = ALU_ADD;
        bus.srcA    = '0;
        bus.srcB    = '0;

        drive("rst0_add", 1'b1, ALU_ADD, 32'd25, 32'd26, 32'h0000_0033);
        drive("rst1_add", 1'b1, ALU_ADD, 32'd25, 32'd26, 32'h0000_0033);

        drive("add",       1'b0, ALU_ADD,  32'd25,        32'd26,        32'h0000_0033);
        drive("add_wrap",  1'b0, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        drive("sub_neg",   1'b0, ALU_SUB,  32'd25,        32'd26,        32'hFFFF_FFFF);
        drive("sub_max",   1'b0, ALU_SUB,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        drive("or",        1'b0, ALU_OR,   32'h0000_AAAA, 32'h0000_5555, 32'h0000_FFFF);
        drive("and",       1'b0, ALU_AND,  32'h0000_AAAA, 32'h0000_5555, 32'h0000_0000);
        drive("xor",       1'b0, ALU_XOR,  32'h0000_AAAA, 32'h0000_5555, 32'h0000_FFFF);
        drive("srl5",      1'b0, ALU_SRL,  32'h0000_FF00, 32'h0000_0085, 32'h0000_07F8);
        drive("sll5",      1'b0, ALU_SLL,  32'h0000_FF00, 32'h0000_0085, 32'h001F_E000);
        drive("sra5",      1'b0, ALU_SRA,  32'h8000_FF00, 32'h0000_0085, 32'hFC00_07F8);
        drive("srl5_neg",  1'b0, ALU_SRL,  32'h8000_FF00, 32'h0000_0085, 32'h0400_07F8);
        drive("sll0",      1'b0, ALU_SLL,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678);
        drive("sra0",      1'b0, ALU_SRA,  32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321);
        drive("sll31",     1'b0, ALU_SLL,  32'h0000_0003, 32'h0000_001F, 32'h8000_0000);
        drive("srl31",     1'b0, ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
        drive("sra31",     1'b0, ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);
        drive("sra_pos",   1'b0, ALU_SRA,  32'h7000_0000, 32'h0000_0004, 32'h0700_0000);
        drive("slt_opp",   1'b0, ALU_SLT,  32'h8000_FF00, 32'h0000_0005, 32'h0000_0001);
        drive("sltu_opp",  1'b0, ALU_SLTU, 32'h8000_FF00, 32'h0000_0005, 32'h0000_0000);
        drive("slt_eq",    1'b0, ALU_SLT,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000);
        drive("sltu_lt",   1'b0, ALU_SLTU, 32'h0000_0005, 32'h8000_FF00, 32'h0000_0001);
        drive("slt_m1",    1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        drive("slt_gt",    1'b0, ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
        drive("lui",       1'b0, ALU_LUI,  32'h0000_FF00, 32'h0000_0FFF, 32'h0000_FF00);
        drive("fun10",     1'b0, 4'd10,    32'h0000_FF00, 32'h0000_0FFF, 32'h0000_0000);
        drive("fun12",     1'b0, 4'd12,    32'h0000_FF00, 32'h0000_0FFF, 32'h0000_0000);
        drive("fun14",     1'b0, 4'd14,    32'h0000_FF00, 32'h0000_0FFF, 32'h0000_0000);
        drive("fun15",     1'b0, 4'd15,    32'h0000_FF00, 32'h0000_0FFF, 32'h0000_0000);
        drive("add_pre",   1'b0, ALU_ADD,  32'h0000_1000, 32'h0000_0234, 32'h0000_1234);
        drive("rst_wins",  1'b1, ALU_OR,   32'h0000_AAAA, 32'h0000_5555, 32'h0000_FFFF);
        drive("post_rst",  1'b0, ALU_XOR,  32'hDEAD_BEEF, 32'hFFFF_0000, 32'h2152_BEEF);

        begin : drain
            int unsigned budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d entries left expected 0", exp_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
